core_issue_ctrl: RTL and testbench
==================================

// Module: core_issue_ctrl
// PURPOSE
//  Pipeline sequencer between the decode latch and execute. It keeps a per-register pending-write scoreboard
//  and detects RAW/WAW hazards on the decoded ra/rb/rd fields. It sequences multi-cycle mul and load/store
//  (memory handshake) and drives the stall/flush inputs of fetch and decode. An insn leaves decode only when issue=1.
// PARAMETERS
//  NUM_REGS     16  architectural registers; index 0 is R0 (hardwired zero, never tracked)
//  REG_W        4   register index width, $clog2(NUM_REGS)
//  MUL_LATENCY  3   execute cycles of a mul, >=1; MUL_LATENCY-1 extra stall cycles after a mul issues
// PORTS
//  clk            in   1         single clock, all state on posedge
//  rst            in   1         synchronous, active-high reset
//  dec_valid      in   1         decode latch holds a real insn (any ctrl bit set; 0 for NOP/flushed)
//  dec_uses_ra    in   1         insn reads ra
//  dec_uses_rb    in   1         insn reads rb
//  dec_writeback  in   1         insn writes rd
//  dec_ra         in   REG_W     source A index
//  dec_rb         in   REG_W     source B index
//  dec_rd         in   REG_W     destination index
//  dec_mul        in   1         insn is mul
//  dec_ldst       in   1         insn is load/store
//  wb_valid       in   1         writeback stage commits wb_rd this cycle
//  wb_rd          in   REG_W     committed destination
//  branch_taken   in   1         execute resolved a taken branch this cycle
//  mem_ack        in   1         memory completes outstanding access
//  issue          out  1         decode insn dispatched to execute this cycle
//  stall          out  1         hold fetch and decode latches
//  flush          out  1         clear decode latch (registered pulse)
//  mem_req        out  1         load/store access outstanding
//  scoreboard     out  NUM_REGS  pending-write bits (debug/verification)
// BEHAVIOUR
//  Reset: state=RUN, scoreboard=0, cnt=0, flush=0, mem_req=0. issue=0 and stall=0 in the reset cycle.
//  Effective scoreboard sb_eff = scoreboard & ~(wb_valid ? 1<<wb_rd : 0): same-cycle commit counts as resolved.
//  hazard = dec_valid & ((uses_ra & sb_eff[ra]) | (uses_rb & sb_eff[rb]) | (writeback & sb_eff[rd])).
//  issue = (state==RUN) & dec_valid & ~hazard & ~branch_taken & ~flush. Comb, same cycle.
//  stall = (state!=RUN) | (state==RUN & hazard & ~branch_taken). Comb.
//  Scoreboard next: clear bit wb_rd on wb_valid, then set bit dec_rd on issue&writeback. Set wins on the same index.
//    Bit 0 is never set. A wb for a clear bit is a no-op.
//  States:
//    RUN: issue of mul with MUL_LATENCY>1 -> MUL_WAIT, cnt<=MUL_LATENCY-1; issue of ldst -> MEM_WAIT, mem_req<=1.
//    MUL_WAIT: stall=1, issue=0. cnt decrements each cycle; cnt==1 -> RUN.
//      Mul at cycle T => stall T+1..T+MUL_LATENCY-1, next issue no earlier than T+MUL_LATENCY.
//    MEM_WAIT: stall=1, mem_req=1. mem_ack=1 -> mem_req<=0, state<=RUN (issue possible next cycle).
//      mem_ack outside MEM_WAIT is ignored.
//  flush <= branch_taken: 1-cycle pulse at N+1 for branch at N. Also pulsed while in MUL_WAIT/MEM_WAIT.
//    Does not abort mul/mem (older insns) and does not alter scoreboard (wrong-path insns never issued).
//  branch_taken and a hazard in the same cycle: issue=0, stall=0 so the wrong-path insn is flushed, not held.
//  Back-to-back branch_taken: flush high each following cycle.
//  rst mid-MUL_WAIT/MEM_WAIT: mem_req drops the next edge, scoreboard cleared, pending mem_ack ignored.
// STRUCTURE
//  Shared package (core/uarch.sv): reg_num typedef (REG_W bits), issue_state enum {ISSUE_RUN, ISSUE_MUL_WAIT,
//    ISSUE_MEM_WAIT}, `R0 constant.
//  One sub-module: core_issue_scoreboard (pending bits, set/clear priority, sb_eff and hazard compare).
//  FSM, cnt and flush/mem_req registers stay in the top.
// TESTING
//  1 alu r3 (wb) at T, then alu reading r3 at T+1, wb_valid r3 at T+3 -> stall T+1..T+2, issue at T+3, scoreboard[3]=0 at T+4.
//  2 mul r5 at T, MUL_LATENCY=3, independent alu at T+1 -> stall at T+1,T+2; alu issues at T+3.
//  3 load r2 at T, mem_ack at T+4 -> mem_req and stall high T+1..T+4; RUN at T+5; scoreboard[2] stays set until wb r2.
//  4 branch_taken at T while decode holds an insn reading pending r4 -> issue=0, stall=0 at T; flush=1 at T+1 only.
//  5 wb_valid r6 and issue writing r6 in the same cycle -> scoreboard[6]=1 next cycle; write to r0 never sets bit 0.
//  6 rst at T+2 during MEM_WAIT with scoreboard=16'h0024 -> T+3: RUN, mem_req=0, scoreboard=0; mem_ack at T+3 ignored.

Source files
------------

// File: rtl/core_issue_ctrl_pkg.sv
// Shared issue-control types: register index, FSM state encodings, R0 constant
// and a small one-hot helper used by the pending-write scoreboard.
package core_issue_ctrl_pkg;

  localparam int NUM_REGS = 16;
  localparam int REG_W    = $clog2(NUM_REGS);

  typedef logic [REG_W-1:0] reg_num;
  typedef logic [1:0]       issue_state;

  localparam issue_state ISSUE_RUN      = 2'd0;
  localparam issue_state ISSUE_MUL_WAIT = 2'd1;
  localparam issue_state ISSUE_MEM_WAIT = 2'd2;

  // R0 is hardwired zero and is never tracked as pending
  localparam reg_num R0 = '0;

  // One-hot mask for register r, or all-zero when en is low
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic en, input reg_num r);
    logic [NUM_REGS-1:0] m;
    m = '0;
    if (en) m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/core_issue_ctrl_if.sv
// Decode/writeback/execute/memory signals seen by the issue controller.
// master: the surrounding pipeline; slave: the issue controller.
interface core_issue_ctrl_if
  import core_issue_ctrl_pkg::*;
  ();

  logic                dec_valid;
  logic                dec_uses_ra;
  logic                dec_uses_rb;
  logic                dec_writeback;
  reg_num              dec_ra;
  reg_num              dec_rb;
  reg_num              dec_rd;
  logic                dec_mul;
  logic                dec_ldst;
  logic                wb_valid;
  reg_num              wb_rd;
  logic                branch_taken;
  logic                mem_ack;
  logic                issue;
  logic                stall;
  logic                flush;
  logic                mem_req;
  logic [NUM_REGS-1:0] scoreboard;

  modport master (
    output dec_valid, dec_uses_ra, dec_uses_rb, dec_writeback,
           dec_ra, dec_rb, dec_rd, dec_mul, dec_ldst,
           wb_valid, wb_rd, branch_taken, mem_ack,
    input  issue, stall, flush, mem_req, scoreboard
  );

  modport slave (
    input  dec_valid, dec_uses_ra, dec_uses_rb, dec_writeback,
           dec_ra, dec_rb, dec_rd, dec_mul, dec_ldst,
           wb_valid, wb_rd, branch_taken, mem_ack,
    output issue, stall, flush, mem_req, scoreboard
  );

endinterface

// File: rtl/core_issue_ctrl_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, cleared by
// writeback commit and set by issue of a writing insn (set wins on the same
// index). Also produces the RAW/WAW hazard for the insn sitting in decode.
module core_issue_scoreboard
  import core_issue_ctrl_pkg::*;
  (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_valid_i,
  input  reg_num              wb_rd_i,
  input  logic                set_i,
  input  reg_num              set_rd_i,
  input  logic                dec_valid_i,
  input  logic                uses_ra_i,
  input  logic                uses_rb_i,
  input  logic                writeback_i,
  input  reg_num              ra_i,
  input  reg_num              rb_i,
  input  reg_num              rd_i,
  output logic                hazard_o,
  output logic [NUM_REGS-1:0] pending_o
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic [NUM_REGS-1:0] sb_eff;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] set_mask;

  // A same-cycle commit already resolves its register; R0 is never marked pending
  always_comb begin
    clr_mask  = reg_onehot(wb_valid_i, wb_rd_i);
    set_mask  = reg_onehot(set_i && (set_rd_i != R0), set_rd_i);
    sb_eff    = pending_q & ~clr_mask;
    pending_d = sb_eff | set_mask;
    hazard_o  = dec_valid_i & ((uses_ra_i   & sb_eff[ra_i]) |
                               (uses_rb_i   & sb_eff[rb_i]) |
                               (writeback_i & sb_eff[rd_i]));
  end

  // Pending bits register; cleared on reset
  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/core_issue_ctrl.sv
// Issue sequencer between decode and execute: gates dispatch on scoreboard
// hazards, holds the front end during multi-cycle mul and outstanding memory
// accesses, and turns a taken branch into a one-cycle decode flush.
module core_issue_ctrl
  import core_issue_ctrl_pkg::*;
  #(
  parameter int MUL_LATENCY = 3
  ) (
  input  logic             clk,
  input  logic             rst,
  core_issue_ctrl_if.slave bus
);

  localparam int CNT_W = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic             MUL_MULTI = (MUL_LATENCY > 1);

  issue_state          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                flush_q, flush_d;
  logic                mem_req_q, mem_req_d;
  logic                hazard;
  logic                issue;
  logic                stall;
  logic                in_run;
  logic [NUM_REGS-1:0] pending;

  core_issue_scoreboard u_sb (
    .clk         (clk),
    .rst         (rst),
    .wb_valid_i  (bus.wb_valid),
    .wb_rd_i     (bus.wb_rd),
    .set_i       (issue & bus.dec_writeback),
    .set_rd_i    (bus.dec_rd),
    .dec_valid_i (bus.dec_valid),
    .uses_ra_i   (bus.dec_uses_ra),
    .uses_rb_i   (bus.dec_uses_rb),
    .writeback_i (bus.dec_writeback),
    .ra_i        (bus.dec_ra),
    .rb_i        (bus.dec_rb),
    .rd_i        (bus.dec_rd),
    .hazard_o    (hazard),
    .pending_o   (pending)
  );

  // Dispatch and hold decisions; a taken branch suppresses the hold so the
  // wrong-path insn is flushed rather than kept in decode
  always_comb begin
    in_run = (state_q == ISSUE_RUN);
    issue  = ~rst & in_run & bus.dec_valid & ~hazard & ~bus.branch_taken & ~flush_q;
    stall  = ~rst & (~in_run | (hazard & ~bus.branch_taken));
  end

  // FSM next state, mul countdown and memory request
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_req_d = mem_req_q;
    flush_d   = bus.branch_taken;
    case (state_q)
      ISSUE_RUN: begin
        if (issue) begin
          if (bus.dec_mul && MUL_MULTI) begin
            state_d = ISSUE_MUL_WAIT;
            cnt_d   = CNT_INIT;
          end else if (bus.dec_ldst) begin
            state_d   = ISSUE_MEM_WAIT;
            mem_req_d = 1'b1;
          end
        end
      end
      ISSUE_MUL_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = ISSUE_RUN;
      end
      ISSUE_MEM_WAIT: begin
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = ISSUE_RUN;
        end
      end
      default: begin
        state_d   = ISSUE_RUN;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Control registers; reset returns to RUN and drops any pending access
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ISSUE_RUN;
      cnt_q     <= '0;
      flush_q   <= 1'b0;
      mem_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      flush_q   <= flush_d;
      mem_req_q <= mem_req_d;
    end
  end

  assign bus.issue      = issue;
  assign bus.stall      = stall;
  assign bus.flush      = flush_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.scoreboard = pending;

endmodule

// File: tb/tb_core_issue_ctrl.sv
// Directed bench for core_issue_ctrl: each step drives decode/wb/branch/ack
// inputs, queues the expected outputs for that cycle and checks them mid-cycle.
module tb_core_issue_ctrl;
  import core_issue_ctrl_pkg::*;

  typedef struct {
    logic        iss;
    logic        stl;
    logic        fl;
    logic        mr;
    logic [15:0] sb;
  } exp_t;

  logic   clk;
  logic   rst;
  int     checks;
  int     fails;
  exp_t   exp_q[$];
  string  tag_q[$];

  core_issue_ctrl_if bus ();

  core_issue_ctrl #(.MUL_LATENCY(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.dec_valid     = 1'b0;
    bus.dec_uses_ra   = 1'b0;
    bus.dec_uses_rb   = 1'b0;
    bus.dec_writeback = 1'b0;
    bus.dec_ra        = '0;
    bus.dec_rb        = '0;
    bus.dec_rd        = '0;
    bus.dec_mul       = 1'b0;
    bus.dec_ldst      = 1'b0;
    bus.wb_valid      = 1'b0;
    bus.wb_rd         = '0;
    bus.branch_taken  = 1'b0;
    bus.mem_ack       = 1'b0;
  endtask

  task automatic dec(input logic ura, input reg_num ra, input logic urb, input reg_num rb,
                     input logic wbk, input reg_num rd, input logic mul, input logic ldst);
    bus.dec_valid     = 1'b1;
    bus.dec_uses_ra   = ura;
    bus.dec_ra        = ra;
    bus.dec_uses_rb   = urb;
    bus.dec_rb        = rb;
    bus.dec_writeback = wbk;
    bus.dec_rd        = rd;
    bus.dec_mul       = mul;
    bus.dec_ldst      = ldst;
  endtask

  task automatic commit(input reg_num rd);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = rd;
  endtask

  task automatic compare(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Queue this cycle's expectation, sample mid-cycle, then advance to the next cycle
  task automatic chk(input string tag, input logic iss, input logic stl, input logic fl,
                     input logic mr, input logic [15:0] sb);
    exp_t e;
    string t;
    e.iss = iss; e.stl = stl; e.fl = fl; e.mr = mr; e.sb = sb;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #2;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    compare({t, ".issue"},   {15'd0, bus.issue},   {15'd0, e.iss});
    compare({t, ".stall"},   {15'd0, bus.stall},   {15'd0, e.stl});
    compare({t, ".flush"},   {15'd0, bus.flush},   {15'd0, e.fl});
    compare({t, ".mem_req"}, {15'd0, bus.mem_req}, {15'd0, e.mr});
    compare({t, ".sb"},      bus.scoreboard,       e.sb);
    @(negedge clk);
    idle();
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    idle();
    rst = 1'b1;
    @(negedge clk);

    // reset cycle: a valid writing insn in decode must neither issue nor stall
    dec(0, 0, 0, 0, 1, 3, 0, 0);       chk("rst",   0, 0, 0, 0, 16'h0000);
    rst = 1'b0;

    // RAW on r3 resolved by same-cycle writeback
    dec(0, 0, 0, 0, 1, 3, 0, 0);       chk("t1_T0", 1, 0, 0, 0, 16'h0000);
    dec(1, 3, 0, 0, 1, 7, 0, 0);       chk("t1_T1", 0, 1, 0, 0, 16'h0008);
    dec(1, 3, 0, 0, 1, 7, 0, 0);       chk("t1_T2", 0, 1, 0, 0, 16'h0008);
    dec(1, 3, 0, 0, 1, 7, 0, 0); commit(3); chk("t1_T3", 1, 0, 0, 0, 16'h0008);
    commit(7);                         chk("t1_T4", 0, 0, 0, 0, 16'h0080);
                                       chk("t1_T5", 0, 0, 0, 0, 16'h0000);

    // mul r5 holds issue for MUL_LATENCY-1 cycles
    dec(0, 0, 0, 0, 1, 5, 1, 0);       chk("t2_T0", 1, 0, 0, 0, 16'h0000);
    dec(1, 1, 0, 0, 1, 8, 0, 0);       chk("t2_T1", 0, 1, 0, 0, 16'h0020);
    dec(1, 1, 0, 0, 1, 8, 0, 0);       chk("t2_T2", 0, 1, 0, 0, 16'h0020);
    dec(1, 1, 0, 0, 1, 8, 0, 0);       chk("t2_T3", 1, 0, 0, 0, 16'h0020);
    commit(5);                         chk("t2_T4", 0, 0, 0, 0, 16'h0120);
    commit(8);                         chk("t2_T5", 0, 0, 0, 0, 16'h0100);
                                       chk("t2_T6", 0, 0, 0, 0, 16'h0000);

    // load r2 with ack four cycles later; stray ack in RUN is ignored
    dec(0, 0, 0, 0, 1, 2, 0, 1);       chk("t3_T0", 1, 0, 0, 0, 16'h0000);
    dec(0, 0, 0, 0, 1, 9, 0, 0);       chk("t3_T1", 0, 1, 0, 1, 16'h0004);
    dec(0, 0, 0, 0, 1, 9, 0, 0);       chk("t3_T2", 0, 1, 0, 1, 16'h0004);
    dec(0, 0, 0, 0, 1, 9, 0, 0);       chk("t3_T3", 0, 1, 0, 1, 16'h0004);
    dec(0, 0, 0, 0, 1, 9, 0, 0); bus.mem_ack = 1'b1; chk("t3_T4", 0, 1, 0, 1, 16'h0004);
    dec(0, 0, 0, 0, 1, 9, 0, 0);       chk("t3_T5", 1, 0, 0, 0, 16'h0004);
    commit(9);                         chk("t3_T6", 0, 0, 0, 0, 16'h0204);
    commit(2); bus.mem_ack = 1'b1;     chk("t3_T7", 0, 0, 0, 0, 16'h0004);
    dec(1, 1, 0, 0, 0, 0, 0, 0);       chk("t3_T8", 1, 0, 0, 0, 16'h0000);

    // branch over a hazarded insn, then back-to-back branches
    dec(0, 0, 0, 0, 1, 4, 0, 0);       chk("t4_T0", 1, 0, 0, 0, 16'h0000);
    dec(1, 4, 0, 0, 0, 0, 0, 0); bus.branch_taken = 1'b1; chk("t4_T1", 0, 0, 0, 0, 16'h0010);
    dec(0, 0, 0, 0, 1, 10, 0, 0);      chk("t4_T2", 0, 0, 1, 0, 16'h0010);
    dec(0, 0, 0, 0, 1, 10, 0, 0);      chk("t4_T3", 1, 0, 0, 0, 16'h0010);
    commit(4);                         chk("t4_T4", 0, 0, 0, 0, 16'h0410);
    commit(10); bus.branch_taken = 1'b1; chk("t4_T5", 0, 0, 0, 0, 16'h0400);
    bus.branch_taken = 1'b1;           chk("t4_T6", 0, 0, 1, 0, 16'h0000);
                                       chk("t4_T7", 0, 0, 1, 0, 16'h0000);
                                       chk("t4_T8", 0, 0, 0, 0, 16'h0000);

    // set beats same-cycle clear on r6; writes to r0 never tracked
    dec(0, 0, 0, 0, 1, 6, 0, 0);       chk("t5_T0", 1, 0, 0, 0, 16'h0000);
    dec(0, 0, 0, 0, 1, 6, 0, 0); commit(6); chk("t5_T1", 1, 0, 0, 0, 16'h0040);
    dec(0, 0, 0, 0, 1, 0, 0, 0); commit(6); chk("t5_T2", 1, 0, 0, 0, 16'h0040);
                                       chk("t5_T3", 0, 0, 0, 0, 16'h0000);

    // reset during MEM_WAIT with r2/r5 pending; following ack ignored
    dec(0, 0, 0, 0, 1, 5, 0, 0);       chk("t6_T0", 1, 0, 0, 0, 16'h0000);
    dec(0, 0, 0, 0, 1, 2, 0, 1);       chk("t6_T1", 1, 0, 0, 0, 16'h0020);
    rst = 1'b1; dec(0, 0, 0, 0, 1, 9, 0, 0); chk("t6_T2", 0, 0, 0, 1, 16'h0024);
    rst = 1'b0; bus.mem_ack = 1'b1;    chk("t6_T3", 0, 0, 0, 0, 16'h0000);
    dec(1, 1, 0, 0, 0, 0, 0, 0);       chk("t6_T4", 1, 0, 0, 0, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
